// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI bus arbiter: FSM state encoding,
// default parameter values and the round-robin selection function.
package pci_arb_pkg;

  localparam int unsigned MAX_MASTERS       = 8;
  localparam int unsigned DEF_N_MASTERS     = 4;
  localparam int unsigned DEF_GRANT_TIMEOUT = 16;
  localparam bit          DEF_PARK_EN       = 1'b1;
  localparam int unsigned DEF_PARK_IDX      = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY,
    ST_GAP
  } arb_state_e;

  // First requesting index strictly after 'last', wrapping at n-1 -> 0.
  function automatic logic [2:0] rr_next(input logic [2:0]             last,
                                         input logic [MAX_MASTERS-1:0] req_mask,
                                         input int unsigned            n);
    logic [2:0]  pick;
    logic        found;
    int unsigned cand;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
      cand = (32'(last) + k) % n;
      if (k <= n && !found && req_mask[cand[2:0]]) begin
        pick  = cand[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: chooses the next master to grant
// from the active-high request mask and the previous bus owner.
module pci_rr_picker
  import pci_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = DEF_N_MASTERS
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] last_owner,
  output logic [$clog2(N_MASTERS)-1:0] winner,
  output logic                         any_req
);

  localparam int unsigned IW = $clog2(N_MASTERS);

  logic [2:0] pick;

  always_comb begin
    pick    = rr_next(3'(last_owner), 8'(req), N_MASTERS);
    winner  = pick[IW-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: fair round-robin grant with bus parking,
// grant timeout for idle masters and a forced turnaround between owners.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS     = DEF_N_MASTERS,
  parameter int unsigned GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter bit          PARK_EN       = DEF_PARK_EN,
  parameter int unsigned PARK_IDX      = DEF_PARK_IDX
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic [N_MASTERS-1:0]         REQ_,
  input  logic                         FRAME_,
  input  logic                         IRDY_,
  output logic [N_MASTERS-1:0]         GNT_,
  output logic [$clog2(N_MASTERS)-1:0] gnt_idx,
  output logic                         gnt_valid,
  output logic                         timeout
);

  localparam int unsigned          IW       = $clog2(N_MASTERS);
  localparam int unsigned          CW       = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [CW-1:0]        CNT_MAX  = CW'(GRANT_TIMEOUT - 1);
  localparam logic [IW-1:0]        PARK     = IW'(PARK_IDX);
  localparam logic [IW-1:0]        LAST_RST = IW'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] ONE      = N_MASTERS'(1);

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] req, own_mask, gnt_d;
  logic [IW-1:0]        winner, idx_d, last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 any_req, other_req, bus_idle, parked, valid_d, timeout_d;

  assign req       = ~REQ_;
  assign bus_idle  = FRAME_ & IRDY_;
  assign own_mask  = ONE << gnt_idx;
  assign other_req = |(req & ~own_mask);
  assign parked    = (state_q == ST_IDLE) && !GNT_[PARK];

  pci_rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
    .req        (req),
    .last_owner (last_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = GNT_;
    idx_d     = gnt_idx;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      // GAP takes the IDLE decision on its exit edge, so a pending request
      // is granted right after the single all-high turnaround cycle.
      ST_IDLE, ST_GAP: begin
        if (any_req && !(parked && winner != PARK)) begin
          state_d = ST_GRANT;
          gnt_d   = ~(ONE << winner);
          idx_d   = winner;
          cnt_d   = '0;
        end else if (any_req) begin
          state_d = ST_GAP;
          gnt_d   = '1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = PARK_EN ? ~(ONE << PARK) : '1;
        end
      end
      ST_GRANT: begin
        if (!FRAME_) begin
          state_d = ST_BUSY;
          last_d  = gnt_idx;
        end else if (!req[gnt_idx]) begin
          state_d = ST_GAP;
          gnt_d   = '1;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_GAP;
          gnt_d     = '1;
          timeout_d = 1'b1;
          last_d    = gnt_idx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (bus_idle) begin
          if (other_req || !req[gnt_idx]) begin
            state_d = ST_GAP;
            gnt_d   = '1;
          end else begin
            state_d = ST_GRANT;
            gnt_d   = ~own_mask;
            cnt_d   = '0;
          end
        end else begin
          gnt_d = other_req ? '1 : ~own_mask;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '1;
      end
    endcase
    valid_d = (state_d == ST_GRANT) || (state_d == ST_BUSY);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= ST_IDLE;
      GNT_      <= '1;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      GNT_      <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
